ins_loader: RTL and testbench

INS_LOADER -- requirements
Module: ins_loader

---
 rtl/ins_loader_pkg.sv | 44 ++++
 rtl/ins_loader_chk.sv | 48 ++++
 rtl/ins_loader.sv | 139 +++++++++++++
 tb/tb_ins_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_loader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ins_loader_pkg: FSM state encoding and frame constants shared by the program loader.
// The CHK state only exists when INS_LOADER_CHKSUM_EN is defined.
package ins_loader_pkg;

    localparam int HDR_LEN = 2;
    localparam int CHK_LEN = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_H  = 3'd1,
        ST_LEN_L  = 3'd2,
        ST_DATA_H = 3'd3,
        ST_DATA_L = 3'd4,
`ifdef INS_LOADER_CHKSUM_EN
        ST_CHK    = 3'd5,
`endif
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    // Where the FSM goes once the last word (or an empty program) has been taken.
`ifdef INS_LOADER_CHKSUM_EN
    localparam state_t ST_AFTER_DATA = ST_CHK;
`else
    localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

    function automatic logic is_rx_state(input state_t s);
        logic r;
        r = 1'b0;
        case (s)
            ST_LEN_H, ST_LEN_L, ST_DATA_H, ST_DATA_L: r = 1'b1;
`ifdef INS_LOADER_CHKSUM_EN
            ST_CHK:                                  r = 1'b1;
`endif
            default:                                 r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ins_loader_chk.sv
`timescale 1ns/1ps
`default_nettype none
// ins_loader_chk: pairs high/low bytes into 16-bit values and, when
// INS_LOADER_CHKSUM_EN is defined, keeps the running XOR of accepted frame bytes.
module ins_loader_chk (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        hi_load_i,
    input  logic [7:0]  byte_i,
`ifdef INS_LOADER_CHKSUM_EN
    input  logic        clr_i,
    input  logic        acc_i,
    output logic [7:0]  chk_o,
`endif
    output logic [15:0] pair_o
);

    logic [7:0] hi_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_q <= 8'h00;
        end else if (hi_load_i) begin
            hi_q <= byte_i;
        end
    end

    // The low byte is used straight off the input in the cycle it is accepted.
    assign pair_o = {hi_q, byte_i};

`ifdef INS_LOADER_CHKSUM_EN
    logic [7:0] chk_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chk_q <= 8'h00;
        end else if (clr_i) begin
            chk_q <= 8'h00;
        end else if (acc_i) begin
            chk_q <= chk_q ^ byte_i;
        end
    end

    assign chk_o = chk_q;
`endif

endmodule
`default_nettype wire

// File: rtl/ins_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ins_loader: receives a length-prefixed program over a byte stream and writes it
// into instruction memory, holding the CPU in reset until a load completes (INS_LOADER_CHKSUM_EN adds checksum).
module ins_loader
    import ins_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [7:0]        RxData,
    input  logic              RxValid,
    output logic              RxReady,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [15:0]       MemWData,
    output logic              WE_IMEM,
    output logic              CpuRst,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic              rx_ready_q, we_q, cpu_rst_q, busy_q, done_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q, len_q;

    logic              w_acc, w_start, w_last, w_hi_load;
    logic [15:0]       w_pair;

    assign w_acc     = RxValid && rx_ready_q;
    assign w_start   = Start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign w_last    = (addr_q == ADDR_W'(len_q - 16'd1));
    assign w_hi_load = w_acc && (state_q == ST_LEN_H || state_q == ST_DATA_H);

`ifdef INS_LOADER_CHKSUM_EN
    logic [7:0] w_chk;
    logic       w_chk_acc;

    assign w_chk_acc = w_acc && (state_q != ST_CHK);
`endif

    ins_loader_chk u_chk (
        .clk_i     (Clk),
        .rst_ni    (Rst_n),
        .hi_load_i (w_hi_load),
        .byte_i    (RxData),
`ifdef INS_LOADER_CHKSUM_EN
        .clr_i     (w_start),
        .acc_i     (w_chk_acc),
        .chk_o     (w_chk),
`endif
        .pair_o    (w_pair)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (w_start) state_d = ST_LEN_H;
            end
            ST_LEN_H: begin
                if (w_acc) state_d = ST_LEN_L;
            end
            ST_LEN_L: begin
                if (w_acc) begin
                    if ({1'b0, w_pair} > MAX_WORDS) state_d = ST_ERR;
                    else if (w_pair == 16'd0)       state_d = ST_AFTER_DATA;
                    else                            state_d = ST_DATA_H;
                end
            end
            ST_DATA_H: begin
                if (w_acc) state_d = ST_DATA_L;
            end
            ST_DATA_L: begin
                if (w_acc) state_d = w_last ? ST_AFTER_DATA : ST_DATA_H;
            end
`ifdef INS_LOADER_CHKSUM_EN
            ST_CHK: begin
                if (w_acc) state_d = (RxData == w_chk) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 16'h0000;
            len_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= is_rx_state(state_d);
            busy_q     <= is_rx_state(state_d);
            done_q     <= (state_d == ST_DONE);
            err_q      <= (state_d == ST_ERR);
            cpu_rst_q  <= (state_d != ST_DONE);
            we_q       <= w_acc && (state_q == ST_DATA_L);

            if (w_acc && state_q == ST_LEN_L) begin
                len_q <= w_pair;
            end
            if (w_acc && state_q == ST_DATA_L) begin
                wdata_q <= w_pair;
            end

            // Advancing only while words remain keeps the final address from wrapping.
            if (w_start) begin
                addr_q <= '0;
            end else if (we_q && (state_q == ST_DATA_H || state_q == ST_DATA_L)) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign RxReady  = rx_ready_q;
    assign MemAddr  = addr_q;
    assign MemWData = wdata_q;
    assign WE_IMEM  = we_q;
    assign CpuRst   = cpu_rst_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ins_loader.sv
`timescale 1ns/1ps
`default_nettype none
// tb_ins_loader: scoreboard-based bench for the program loader; expected memory
// writes are queued as frames are driven and retired on each WE_IMEM pulse.
module tb_ins_loader;

    localparam int ADDR_W = 8;

    logic              Clk = 1'b0;
    logic              Rst_n;
    logic              Start;
    logic [7:0]        RxData;
    logic              RxValid;
    logic              RxReady;
    logic [ADDR_W-1:0] MemAddr;
    logic [15:0]       MemWData;
    logic              WE_IMEM;
    logic              CpuRst;
    logic              Busy;
    logic              Done;
    logic              Err;

    int errors = 0;
    int checks = 0;

    logic [23:0] sb[$];
    logic [15:0] words[$];

    ins_loader #(.ADDR_W(ADDR_W)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Start    (Start),
        .RxData   (RxData),
        .RxValid  (RxValid),
        .RxReady  (RxReady),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .WE_IMEM  (WE_IMEM),
        .CpuRst   (CpuRst),
        .Busy     (Busy),
        .Done     (Done),
        .Err      (Err)
    );

    always #5 Clk = ~Clk;

    // Retire one expected write per pulse.
    always @(negedge Clk) begin
        if (Rst_n === 1'b1 && WE_IMEM === 1'b1) begin
            logic [23:0] exp_w;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected got addr=%h data=%h required no write", MemAddr, MemWData);
            end else begin
                exp_w = sb.pop_front();
                if ({MemAddr, MemWData} !== exp_w) begin
                    errors++;
                    $display("FAIL write_data got addr=%h data=%h required addr=%h data=%h",
                             MemAddr, MemWData, exp_w[23:16], exp_w[15:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
        repeat (n) @(negedge Clk);
        RxData  = b;
        RxValid = 1'b1;
        for (int k = 0; k < 64 && RxReady !== 1'b1; k++) @(negedge Clk);
        if (RxReady !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout got=%b required=1", RxReady);
        end
        @(negedge Clk);
        RxValid = 1'b0;
    endtask

    task automatic wait_end;
        for (int k = 0; k < 100 && Done !== 1'b1 && Err !== 1'b1; k++) @(negedge Clk);
        @(negedge Clk);
    endtask

    task automatic load(input logic [15:0] n, input int gap, input bit corrupt, input bit glitch);
        logic [7:0] c;
        c = n[15:8] ^ n[7:0];
        pulse_start();
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        if (glitch) begin
            pulse_start();
            checks++;
            if (Busy !== 1'b1 || Done !== 1'b0 || RxReady !== 1'b1) begin
                errors++;
                $display("FAIL start_ignored got busy=%b done=%b ready=%b required 1 0 1", Busy, Done, RxReady);
            end
        end
        for (int i = 0; i < int'(n); i++) begin
            sb.push_back({8'(i), words[i]});
            c = c ^ words[i][15:8] ^ words[i][7:0];
            send_byte(words[i][15:8], gap);
            send_byte(words[i][7:0], gap);
        end
`ifdef INS_LOADER_CHKSUM_EN
        send_byte(corrupt ? (c ^ 8'h01) : c, gap);
`else
        if (corrupt) c = ~c;
`endif
        wait_end();
    endtask

    task automatic test_reset;
        Rst_n = 1'b1; Start = 1'b0; RxValid = 1'b0; RxData = 8'h00;
        #1 Rst_n = 1'b0;
        #1;
        checks++;
        if ({RxReady, WE_IMEM, MemAddr, MemWData, CpuRst, Busy, Done, Err} !== {2'b00, 8'h00, 16'h0000, 4'b1000}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b we=%b addr=%h data=%h cpurst=%b busy=%b done=%b err=%b required 0 0 00 0000 1 0 0 0",
                     RxReady, WE_IMEM, MemAddr, MemWData, CpuRst, Busy, Done, Err);
        end
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_basic;
        words = '{16'h1234, 16'hABCD};
        load(16'd2, 0, 1'b0, 1'b0);
        checks++;
        if ({Done, Err, CpuRst, Busy} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_status got done=%b err=%b cpurst=%b busy=%b required 1 0 0 0", Done, Err, CpuRst, Busy);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL basic_writes got pending=%0d required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back;
        pulse_start();
        checks++;
        if ({CpuRst, Busy, Done, RxReady} !== 4'b1101) begin
            errors++;
            $display("FAIL restart_status got cpurst=%b busy=%b done=%b ready=%b required 1 1 0 1", CpuRst, Busy, Done, RxReady);
        end
        sb.push_back({8'h00, 16'hBEEF});
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
`ifdef INS_LOADER_CHKSUM_EN
        send_byte(8'h00 ^ 8'h01 ^ 8'hBE ^ 8'hEF, 0);
`endif
        wait_end();
        checks++;
        if ({Done, Err, CpuRst} !== 3'b100 || sb.size() != 0) begin
            errors++;
            $display("FAIL restart_load got done=%b err=%b cpurst=%b pending=%0d required 1 0 0 0", Done, Err, CpuRst, sb.size());
        end
    endtask

    task automatic test_bad_chk;
`ifdef INS_LOADER_CHKSUM_EN
        words = '{16'h1234, 16'hABCD};
        load(16'd2, 0, 1'b1, 1'b0);
        checks++;
        if ({Done, Err, CpuRst, Busy} !== 4'b0110) begin
            errors++;
            $display("FAIL bad_chk_status got done=%b err=%b cpurst=%b busy=%b required 0 1 1 0", Done, Err, CpuRst, Busy);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL bad_chk_writes got pending=%0d required 0", sb.size());
        end
`endif
    endtask

    task automatic test_len_overflow;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        checks++;
        if ({Err, Done, Busy, RxReady, CpuRst} !== 5'b10001) begin
            errors++;
            $display("FAIL len_overflow got err=%b done=%b busy=%b ready=%b cpurst=%b required 1 0 0 0 1",
                     Err, Done, Busy, RxReady, CpuRst);
        end
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_full;
        words = {};
        for (int i = 0; i < 256; i++) words.push_back(16'(i * 16'h0101) ^ 16'h5A3C);
        load(16'h0100, 0, 1'b0, 1'b0);
        checks++;
        if ({Done, Err, CpuRst} !== 3'b100) begin
            errors++;
            $display("FAIL full_status got done=%b err=%b cpurst=%b required 1 0 0", Done, Err, CpuRst);
        end
        checks++;
        if (MemAddr !== 8'hFF || sb.size() != 0) begin
            errors++;
            $display("FAIL full_last_addr got addr=%h pending=%0d required addr=ff pending=0", MemAddr, sb.size());
        end
    endtask

    task automatic test_zero_len;
        load(16'd0, 0, 1'b0, 1'b0);
        checks++;
        if ({Done, Err, CpuRst, Busy} !== 4'b1000) begin
            errors++;
            $display("FAIL zero_len got done=%b err=%b cpurst=%b busy=%b required 1 0 0 0", Done, Err, CpuRst, Busy);
        end
    endtask

    task automatic test_gaps_start;
        words = '{16'h1234, 16'hABCD};
        load(16'd2, 4, 1'b0, 1'b1);
        checks++;
        if ({Done, Err, CpuRst} !== 3'b100 || sb.size() != 0) begin
            errors++;
            $display("FAIL gaps_result got done=%b err=%b cpurst=%b pending=%0d required 1 0 0 0", Done, Err, CpuRst, sb.size());
        end
    endtask

    task automatic test_reset_midload;
        pulse_start();
        sb.push_back({8'h00, 16'h1234});
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        #2 Rst_n = 1'b0;
        #1;
        checks++;
        if ({RxReady, WE_IMEM, MemAddr, MemWData, CpuRst, Busy, Done, Err} !== {2'b00, 8'h00, 16'h0000, 4'b1000}) begin
            errors++;
            $display("FAIL midload_reset got rdy=%b we=%b addr=%h data=%h cpurst=%b busy=%b done=%b err=%b required 0 0 00 0000 1 0 0 0",
                     RxReady, WE_IMEM, MemAddr, MemWData, CpuRst, Busy, Done, Err);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL midload_first_write got pending=%0d required 0", sb.size());
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        words = '{16'h1234, 16'hABCD};
        load(16'd2, 0, 1'b0, 1'b0);
        checks++;
        if ({Done, Err, CpuRst} !== 3'b100 || sb.size() != 0) begin
            errors++;
            $display("FAIL midload_reload got done=%b err=%b cpurst=%b pending=%0d required 1 0 0 0", Done, Err, CpuRst, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_bad_chk();
        test_len_overflow();
        test_zero_len();
        test_gaps_start();
        test_full();
        test_reset_midload();
        repeat (3) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
